// File: rtl/lsu.sv
// Load/store unit: one req/ack memory transaction per request, with lane steering,
// load extension and fault reporting. Define MISALIGN_TRAP_EN to trap misaligned accesses.
module lsu #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_DONE = 2'd2} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_r;
  logic [15:0] cnt_r;
  logic        op_r;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;

  logic [1:0]  size_s;
  logic        legal_s;
  logic        trap_s;
  logic [1:0]  off_s;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    byte_en = 4'b0001 << off;
      2'd1:    byte_en = 4'b0011 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'd0:    lane_rep = {4{data[7:0]}};
      2'd1:    lane_rep = {2{data[15:0]}};
      default: lane_rep = data;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'd0:    load_ext = {{24{sh[7]}}, sh[7:0]};
      3'd1:    load_ext = {{16{sh[15]}}, sh[15:0]};
      3'd4:    load_ext = {24'd0, sh[7:0]};
      3'd5:    load_ext = {16'd0, sh[15:0]};
      default: load_ext = word;
    endcase
  endfunction

  // Request decode: legality, misalignment handling and effective lane offset.
  always_comb begin
    size_s  = funct3[1:0];
    legal_s = op_store ? (funct3 <= 3'd2)
                       : ((funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7));
`ifdef MISALIGN_TRAP_EN
    off_s = addr[1:0];
    case (size_s)
      2'd1:    trap_s = addr[0];
      2'd2:    trap_s = (addr[1:0] != 2'b00);
      default: trap_s = 1'b0;
    endcase
`else
    trap_s = 1'b0;
    case (size_s)
      2'd1:    off_s = {addr[1], 1'b0};
      2'd2:    off_s = 2'b00;
      default: off_s = addr[1:0];
    endcase
`endif
  end

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 16'd0;
      op_r       <= 1'b0;
      f3_r       <= 3'd0;
      off_r      <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= 32'd0;
      fault      <= 1'b0;
      fault_code <= 2'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'd0;
      mem_wdata  <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            op_r  <= op_store;
            f3_r  <= funct3;
            off_r <= off_s;
            cnt_r <= 16'd0;
            busy  <= 1'b1;
            if (!legal_s || trap_s) begin
              // Faulting requests never touch memory.
              state_r    <= ST_DONE;
              done       <= 1'b1;
              fault      <= 1'b1;
              fault_code <= legal_s ? 2'd1 : 2'd3;
            end else begin
              state_r   <= ST_REQ;
              mem_req   <= 1'b1;
              mem_we    <= op_store;
              mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
              mem_be    <= byte_en(size_s, off_s);
              mem_wdata <= lane_rep(size_s, wdata);
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state_r    <= ST_DONE;
            done       <= 1'b1;
            fault      <= 1'b0;
            fault_code <= 2'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            if (!op_r) begin
              rdata <= load_ext(f3_r, off_r, mem_rdata);
            end
          end else if (cnt_r == CNT_LAST) begin
            state_r    <= ST_DONE;
            done       <= 1'b1;
            fault      <= 1'b1;
            fault_code <= 2'd2;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized accesses
// checked against an arithmetic reference model.
module tb_lsu;
  localparam int AW = 32;
  localparam int TO = 4;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, op_store = 1'b0;
  logic [2:0] funct3 = 3'd0;
  logic [AW-1:0] addr = '0;
  logic [31:0] wdata = 32'd0, mem_rdata = 32'd0;
  logic mem_ack = 1'b0;
  logic busy, done, fault, mem_req, mem_we;
  logic [31:0] rdata, mem_wdata;
  logic [1:0] fault_code;
  logic [AW-1:0] mem_addr;
  logic [3:0] mem_be;

  int n_tests = 0, n_fail = 0;
  logic [31:0] exp_rd = 32'd0;

  int ob_lat, ob_req;
  logic ob_stable, ob_we, ob_fault, ob_busy_after;
  logic [AW-1:0] ob_addr;
  logic [3:0] ob_be;
  logic [31:0] ob_wd, ob_rd;
  logic [1:0] ob_code;

  lsu #(.TIMEOUT(TO), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .op_store(op_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .fault(fault), .fault_code(fault_code), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Drives one request, answers REQ cycles, records what the DUT did.
  task automatic run_txn(input logic op, input logic [2:0] f3, input logic [AW-1:0] a,
                         input logic [31:0] wd, input int ack_at, input logic [31:0] rword,
                         input bit poke);
    ob_lat = -1; ob_req = 0; ob_stable = 1'b1; ob_we = 1'b0;
    ob_addr = '0; ob_be = 4'd0; ob_wd = 32'd0;
    ob_rd = 32'd0; ob_fault = 1'b0; ob_code = 2'd0;
    op_store = op; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
    mem_ack = 1'b0; mem_rdata = rword;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      start = poke;
      if (poke) begin addr = $urandom; wdata = $urandom; end
      if (mem_req) begin
        if (ob_req == 0) begin
          ob_addr = mem_addr; ob_be = mem_be; ob_wd = mem_wdata; ob_we = mem_we;
        end else if (mem_addr !== ob_addr || mem_be !== ob_be || mem_wdata !== ob_wd ||
                     mem_we !== ob_we) begin
          ob_stable = 1'b0;
        end
        mem_ack = (ob_req == ack_at);
        ob_req++;
      end else begin
        mem_ack = poke;
      end
      if (done) begin
        ob_lat = c; ob_rd = rdata; ob_fault = fault; ob_code = fault_code;
        break;
      end
    end
    start = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    ob_busy_after = busy | done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({busy, done, fault, fault_code, mem_req, mem_we, mem_be} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b required 0", {busy, done, fault, fault_code, mem_req, mem_we, mem_be});
    end
    n_tests++;
    if (rdata !== 32'd0 || mem_addr !== '0 || mem_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data got rdata=%h addr=%h wdata=%h required 0", rdata, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    exp_rd = 32'd0;
  endtask

  task automatic test_lw();
    run_txn(1'b0, 3'd2, 32'h104, 32'd0, 0, 32'hDEADBEEF, 1'b0);
    n_tests++;
    if (ob_lat !== 2 || ob_req !== 1) begin
      n_fail++; $display("FAIL lw_latency got lat=%0d req=%0d required 2/1", ob_lat, ob_req);
    end
    n_tests++;
    if (ob_addr !== 32'h104 || ob_be !== 4'b1111 || ob_we !== 1'b0) begin
      n_fail++; $display("FAIL lw_bus got addr=%h be=%b we=%b required 104/1111/0", ob_addr, ob_be, ob_we);
    end
    n_tests++;
    if (ob_rd !== 32'hDEADBEEF || ob_fault !== 1'b0) begin
      n_fail++; $display("FAIL lw_data got rdata=%h fault=%b required deadbeef/0", ob_rd, ob_fault);
    end
    exp_rd = 32'hDEADBEEF;
  endtask

  task automatic test_sb();
    run_txn(1'b1, 3'd0, 32'h203, 32'h000000A5, 1, 32'h0, 1'b0);
    n_tests++;
    if (ob_we !== 1'b1 || ob_be !== 4'b1000 || ob_addr !== 32'h200 || ob_wd !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL sb_bus got we=%b be=%b addr=%h wd=%h required 1/1000/200/a5a5a5a5", ob_we, ob_be, ob_addr, ob_wd);
    end
    n_tests++;
    if (ob_lat !== 3 || ob_stable !== 1'b1 || ob_rd !== exp_rd || ob_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_done got lat=%0d stable=%b rdata=%h fault=%b required 3/1/%h/0", ob_lat, ob_stable, ob_rd, ob_fault, exp_rd);
    end
  endtask

  task automatic test_lh_lhu();
    run_txn(1'b0, 3'd1, 32'h012, 32'd0, 0, 32'h80010000, 1'b0);
    n_tests++;
    if (ob_rd !== 32'hFFFF8001 || ob_be !== 4'b1100) begin
      n_fail++; $display("FAIL lh_sext got rdata=%h be=%b required ffff8001/1100", ob_rd, ob_be);
    end
    run_txn(1'b0, 3'd5, 32'h012, 32'd0, 0, 32'h80010000, 1'b0);
    n_tests++;
    if (ob_rd !== 32'h00008001) begin
      n_fail++; $display("FAIL lhu_zext got rdata=%h required 00008001", ob_rd);
    end
    exp_rd = 32'h00008001;
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 3'd2, 32'h300, 32'd0, -1, 32'h12345678, 1'b1);
    n_tests++;
    if (ob_req !== TO || ob_lat !== TO + 1 || ob_stable !== 1'b1 || ob_addr !== 32'h300) begin
      n_fail++;
      $display("FAIL timeout_req got req=%0d lat=%0d stable=%b addr=%h required %0d/%0d/1/300", ob_req, ob_lat, ob_stable, ob_addr, TO, TO + 1);
    end
    n_tests++;
    if (ob_fault !== 1'b1 || ob_code !== 2'd2 || ob_rd !== exp_rd || ob_busy_after !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_fault got fault=%b code=%0d rdata=%h busy_after=%b required 1/2/%h/0", ob_fault, ob_code, ob_rd, ob_busy_after, exp_rd);
    end
  endtask

  task automatic test_misalign();
    run_txn(1'b0, 3'd2, 32'h102, 32'd0, 0, 32'hCAFEF00D, 1'b0);
`ifdef MISALIGN_TRAP_EN
    n_tests++;
    if (ob_lat !== 1 || ob_req !== 0 || ob_fault !== 1'b1 || ob_code !== 2'd1 || ob_rd !== exp_rd) begin
      n_fail++;
      $display("FAIL misalign_trap got lat=%0d req=%0d fault=%b code=%0d rdata=%h required 1/0/1/1/%h", ob_lat, ob_req, ob_fault, ob_code, ob_rd, exp_rd);
    end
`else
    n_tests++;
    if (ob_addr !== 32'h100 || ob_be !== 4'b1111 || ob_fault !== 1'b0 || ob_code !== 2'd0 || ob_rd !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL misalign_force got addr=%h be=%b fault=%b code=%0d rdata=%h required 100/1111/0/0/cafef00d", ob_addr, ob_be, ob_fault, ob_code, ob_rd);
    end
    exp_rd = 32'hCAFEF00D;
`endif
  endtask

  task automatic test_illegal();
    run_txn(1'b0, 3'd3, 32'h400, 32'd0, 0, 32'h0, 1'b0);
    n_tests++;
    if (ob_lat !== 1 || ob_req !== 0 || ob_fault !== 1'b1 || ob_code !== 2'd3 || ob_rd !== exp_rd) begin
      n_fail++;
      $display("FAIL illegal_f3 got lat=%0d req=%0d fault=%b code=%0d rdata=%h required 1/0/1/3/%h", ob_lat, ob_req, ob_fault, ob_code, ob_rd, exp_rd);
    end
  endtask

  task automatic test_rst_mid();
    int dones;
    op_store = 1'b0; funct3 = 3'd2; addr = 32'h500; start = 1'b1; mem_ack = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_req got mem_req=%b required 1", mem_req);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    dones = done;
    rst = 1'b0;
    n_tests++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_drop got mem_req=%b busy=%b required 0/0", mem_req, busy);
    end
    repeat (TO + 3) begin @(posedge clk); #1; dones += done; end
    n_tests++;
    if (dones !== 0) begin
      n_fail++; $display("FAIL rst_mid_nodone got %0d done pulses required 0", dones);
    end
    exp_rd = 32'd0;
  endtask

  task automatic test_random();
    logic op; logic [2:0] f3; logic [31:0] a, wd, rw;
    int ack_at, e_lat, e_req; logic [1:0] e_code;
    longint sz, o, ea, v;
    logic [AW-1:0] e_addr; logic [3:0] e_be; logic [31:0] e_wd;
    bit legal, trapm;
`ifdef MISALIGN_TRAP_EN
    trapm = 1'b1;
`else
    trapm = 1'b0;
`endif
    for (int i = 0; i < 200; i++) begin
      op = 1'($urandom);
      f3 = 3'($urandom);
      if ($urandom % 8 != 0) f3 = op ? 3'($urandom % 3) : 3'((($urandom % 5) + 3) % 5 == 0 ? 4 : ($urandom % 3));
      if ($urandom % 6 == 0) f3 = op ? 3'd1 : 3'd5;
      a = $urandom; wd = $urandom; rw = $urandom;
      ack_at = ($urandom % 6 == 0) ? -1 : int'($urandom_range(0, 5));
      legal = op ? (f3 <= 3) && (f3 != 3) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      sz = longint'(1) << f3[1:0];
      e_addr = '0; e_be = 4'd0; e_wd = 32'd0;
      if (!legal) begin
        e_code = 2'd3; e_lat = 1; e_req = 0;
      end else if (trapm && (longint'(a) % sz) != 0) begin
        e_code = 2'd1; e_lat = 1; e_req = 0;
      end else begin
        ea = longint'(a) - (longint'(a) % sz);
        o = ea % 4;
        e_addr = AW'(ea - o);
        e_be = 4'(((longint'(1) << sz) - 1) << o);
        e_wd = (sz == 1) ? 32'((longint'(wd) % 256) * 32'h01010101) :
               (sz == 2) ? 32'((longint'(wd) % 65536) * 32'h00010001) : wd;
        if (ack_at < 0 || ack_at >= TO) begin
          e_code = 2'd2; e_lat = TO + 1; e_req = TO;
        end else begin
          e_code = 2'd0; e_lat = ack_at + 2; e_req = ack_at + 1;
          if (!op) begin
            v = (longint'(rw) >> (8 * o)) % (longint'(1) << (8 * sz));
            if (f3 < 4 && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
            exp_rd = 32'(v);
          end
        end
      end
      run_txn(op, f3, a, wd, ack_at, rw, 1'($urandom));
      n_tests++;
      if (ob_lat !== e_lat || ob_req !== e_req || ob_code !== e_code || ob_fault !== (e_code != 2'd0)) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d] got lat=%0d req=%0d code=%0d fault=%b required %0d/%0d/%0d", i, ob_lat, ob_req, ob_code, ob_fault, e_lat, e_req, e_code);
      end
      n_tests++;
      if (e_req > 0 && (ob_addr !== e_addr || ob_be !== e_be || ob_wd !== e_wd || ob_we !== op || ob_stable !== 1'b1)) begin
        n_fail++;
        $display("FAIL rand_bus[%0d] got addr=%h be=%b wd=%h we=%b stable=%b required %h/%b/%h/%b/1", i, ob_addr, ob_be, ob_wd, ob_we, ob_stable, e_addr, e_be, e_wd, op);
      end
      n_tests++;
      if (ob_rd !== exp_rd || ob_busy_after !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_rdata[%0d] got rdata=%h busy_after=%b required %h/0", i, ob_rd, ob_busy_after, exp_rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sb();
    test_lh_lhu();
    test_timeout();
    test_misalign();
    test_illegal();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu.md
Name: lsu

Overview:
Load/store unit that sits directly downstream of the ALU in the multi-cycle core. It consumes the execute-stage effective address and store data, runs a req/ack transaction against word-organised data memory, and returns aligned, sign- or zero-extended load data to write-back. It also reports misalignment, illegal width and bus-timeout faults.

Parameters:
TIMEOUT, 255, max cycles in REQ waiting for mem_ack before a timeout fault (1..65535)
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  request pulse; sampled only in IDLE
op_store  in  1  1=store, 0=load
funct3  in  3  RV32I width/sign code (LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2)
addr  in  ADDR_W  byte effective address from ALU
wdata  in  32  store source register value
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse
rdata  out  32  extended load result; valid while done=1
fault  out  1  valid with done; 1 = access failed
fault_code  out  2  0 none, 1 misaligned, 2 timeout, 3 illegal funct3
mem_req  out  1  memory request
mem_we  out  1  write enable
mem_addr  out  ADDR_W  word address, bits [1:0] always 0
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  read word, valid with mem_ack
mem_ack  in  1  transaction complete

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk. On reset: state=IDLE, busy=0, done=0, fault=0, fault_code=0, rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, timeout counter=0. Asserting rst mid-transaction drops mem_req on the next edge, and no done is produced.
- States are IDLE, REQ, DONE.
- IDLE: on start=1, latch op_store, funct3, addr and wdata.
  - Illegal funct3 (load 3/6/7; store >2): go to DONE with fault_code=3. No memory access.
  - Otherwise go to REQ. mem_req, mem_we, mem_addr, mem_be and mem_wdata are registered and stable for the whole of REQ. The counter clears.
- REQ: mem_req=1.
  - mem_ack=1: go to DONE. For a load, capture the extended data into rdata.
  - Otherwise the counter increments. When the counter equals TIMEOUT-1 and there is no ack, go to DONE with fault_code=2.
  - An ack arriving in the same cycle as the timeout wins: no fault.
- DONE: done=1 and fault=(fault_code!=0) for exactly one cycle; mem_req=0; then return to IDLE. rdata, fault and fault_code hold until the next completion.
- start is ignored whenever busy=1. mem_ack outside REQ is ignored.
- Latency: start at cycle N, mem_req high at N+1; ack at N+1 gives done at N+2.
- Byte enables, with o = addr[1:0]:
  - byte: 4'b0001<<o
  - half: 4'b0011<<o
  - word: 4'b1111
- mem_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Load extraction: select the byte/half lane by o from mem_rdata. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. Example: LB at o=3 with mem_rdata=0x80FFFFFF gives 0xFFFFFF80.
- Misalignment: half with addr[0]=1; word with addr[1:0]!=0. Handling depends on the optional feature below.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a misaligned request goes IDLE->DONE with fault_code=1. No mem_req is issued and rdata is unchanged.
- Undefined: the address is forced to natural alignment (half clears bit 0, word clears bits 1:0). The access proceeds normally with no fault; fault_code=1 is never produced.

Test Plan:
- LW addr=0x104, ack at first REQ cycle, mem_rdata=0xDEADBEEF -> mem_addr=0x104, mem_be=1111, done 2 cycles after start, rdata=0xDEADBEEF, fault=0.
- SB addr=0x203, wdata=0x000000A5 -> mem_we=1, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x200; done after ack.
- LH addr=0x012 with mem_rdata=0x8001_0000 -> rdata=0xFFFF8001; LHU same access -> rdata=0x00008001.
- LW with mem_ack never asserted, TIMEOUT=4 -> mem_req high exactly 4 cycles, then done with fault=1, fault_code=2; second start during busy ignored.
- LW addr=0x102 -> with MISALIGN_TRAP_EN: done next cycle, fault_code=1, no mem_req; without: mem_addr=0x100, be=1111, fault=0.
- funct3=3 load -> done with fault_code=3, no mem_req; rst asserted during REQ -> mem_req=0 next cycle, no done pulse.
